// File: rtl/gt_sweep_pkg.sv
// Shared types and defaults for the comparator sweep checker.
// Optional build macro: GT_SWEEP_STOP_ON_FAIL_EN (see gt_sweep_checker).
package gt_sweep_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_SETTLE = 2;
    localparam int DEF_ERR_W  = 16;

    // Number of (a, b) pairs a full sweep visits at the default width.
    localparam int VEC_COUNT = 1 << (2 * DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        DONE
    } sweep_state_t;

    function automatic int vec_count(input int width);
        return 1 << (2 * width);
    endfunction

endpackage

// File: rtl/gt_vec_gen.sv
// Operand pair generator: a 2*WIDTH-bit counter split into a (upper half)
// and b (lower half), so b sweeps fastest and a advances once per b wrap.
module gt_vec_gen
    import gt_sweep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             last
);

    logic [2*WIDTH-1:0] vec;

    // Clear wins over advance so a restart always begins at the zero vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec <= '0;
        end else if (clear) begin
            vec <= '0;
        end else if (advance) begin
            vec <= vec + 1'b1;
        end
    end

    assign a_out = vec[2*WIDTH-1:WIDTH];
    assign b_out = vec[WIDTH-1:0];
    assign last  = &vec;

endmodule

// File: rtl/gt_sweep_checker.sv
// Exhaustive a > b sweep checker for magnitude comparators.
// Build macro GT_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gt_sweep_checker
    import gt_sweep_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic             dut_agtb,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    // HOLD covers SETTLE-1 cycles; with SETTLE == 1 it is skipped entirely.
    localparam int              CNT_W     = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((SETTLE >= 2) ? SETTLE - 2 : 0);
    localparam bit              SKIP_HOLD = (SETTLE <= 1);

    sweep_state_t     state;
    sweep_state_t     state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic             vec_clear;
    logic             vec_advance;
    logic             vec_last;
    logic             launch;
    logic             mismatch;
    logic             stop_now;

    gt_vec_gen #(
        .WIDTH (WIDTH)
    ) u_vec_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (vec_clear),
        .advance (vec_advance),
        .a_out   (a_out),
        .b_out   (b_out),
        .last    (vec_last)
    );

    assign mismatch = (dut_agtb != (a_out > b_out));

`ifdef GT_SWEEP_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        vec_clear   = 1'b0;
        vec_advance = 1'b0;
        launch      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    vec_clear = 1'b1;
                    if (SKIP_HOLD) state_nxt = SAMPLE;
                    else           state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (vec_last || stop_now) begin
                    state_nxt = DONE;
                end else begin
                    vec_advance = 1'b1;
                    if (SKIP_HOLD) state_nxt = SAMPLE;
                    else           state_nxt = HOLD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // Results are cleared on launch; start is only honoured from IDLE or DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else if (launch) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else if (state == SAMPLE) begin
            if (mismatch) begin
                if (err_count != {ERR_W{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_a     <= a_out;
                    fail_b     <= b_out;
                end
            end
            if (state_nxt == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gt_sweep_checker.sv
// Directed bench for gt_sweep_checker driving a behavioural comparator with
// selectable faults; follows the stop-on-fail build when GT_SWEEP_STOP_ON_FAIL_EN is set.
module tb_gt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  a_out;
    logic [3:0]  b_out;
    logic        dut_agtb;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic        fail_valid;
    logic [3:0]  fail_a;
    logic [3:0]  fail_b;

    int errors = 0;
    int checks = 0;
    int cycles;
    int dutMode = 0;

    gt_sweep_checker #(
        .WIDTH  (4),
        .SETTLE (2),
        .ERR_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_out      (a_out),
        .b_out      (b_out),
        .dut_agtb   (dut_agtb),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_a     (fail_a),
        .fail_b     (fail_b)
    );

    always #5 clk = ~clk;

    // Attached comparator: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
    always_comb begin
        dut_agtb = 1'b0;
        case (dutMode)
            0: dut_agtb = (a_out > b_out);
            1: dut_agtb = 1'b0;
            2: dut_agtb = 1'b1;
            3: dut_agtb = !(a_out > b_out);
            default: dut_agtb = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic startSweep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; -1 on timeout.
    task automatic applyStimulus(input int midStartAt, output int nCycles);
        nCycles = 0;
        while (!done && nCycles < 5000) begin
            @(posedge clk);
            nCycles++;
            @(negedge clk);
            start = (midStartAt != 0) && (nCycles == midStartAt);
        end
        start = 1'b0;
        if (!done) nCycles = -1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},  int'(busy), 0);
        checkOutput({tag, "_done"},  int'(done), 0);
        checkOutput({tag, "_pass"},  int'(pass), 0);
        checkOutput({tag, "_err"},   int'(err_count), 0);
        checkOutput({tag, "_fv"},    int'(fail_valid), 0);
        checkOutput({tag, "_fa"},    int'(fail_a), 0);
        checkOutput({tag, "_fb"},    int'(fail_b), 0);
        checkOutput({tag, "_a"},     int'(a_out), 0);
        checkOutput({tag, "_b"},     int'(b_out), 0);
    endtask

    initial begin
        $display("[TB] start");
        #12;
        checkIdleOutputs("reset");
        @(negedge clk);
        rst = 1'b0;

        dutMode = 0;
        startSweep();
        checkOutput("good_busy_start", int'(busy), 1);
        applyStimulus(0, cycles);
        checkOutput("good_cycles", cycles, 512);
        checkOutput("good_err", int'(err_count), 0);
        checkOutput("good_pass", int'(pass), 1);
        checkOutput("good_fv", int'(fail_valid), 0);
        checkOutput("good_busy_end", int'(busy), 0);
        checkOutput("good_a_last", int'(a_out), 15);
        checkOutput("good_b_last", int'(b_out), 15);

`ifdef GT_SWEEP_STOP_ON_FAIL_EN
        dutMode = 1;
        startSweep();
        applyStimulus(0, cycles);
        checkOutput("stop0_cycles", cycles, 34);
        checkOutput("stop0_err", int'(err_count), 1);
        checkOutput("stop0_a", int'(a_out), 1);
        checkOutput("stop0_b", int'(b_out), 0);
        checkOutput("stop0_fa", int'(fail_a), 1);
        checkOutput("stop0_fb", int'(fail_b), 0);
        checkOutput("stop0_pass", int'(pass), 0);

        dutMode = 3;
        startSweep();
        applyStimulus(0, cycles);
        checkOutput("stopinv_cycles", cycles, 2);
        checkOutput("stopinv_err", int'(err_count), 1);
        checkOutput("stopinv_a", int'(a_out), 0);
        checkOutput("stopinv_b", int'(b_out), 0);
`else
        dutMode = 1;
        startSweep();
        applyStimulus(0, cycles);
        checkOutput("stuck0_cycles", cycles, 512);
        checkOutput("stuck0_err", int'(err_count), 120);
        checkOutput("stuck0_fv", int'(fail_valid), 1);
        checkOutput("stuck0_fa", int'(fail_a), 1);
        checkOutput("stuck0_fb", int'(fail_b), 0);
        checkOutput("stuck0_pass", int'(pass), 0);

        dutMode = 2;
        startSweep();
        applyStimulus(0, cycles);
        checkOutput("stuck1_err", int'(err_count), 136);
        checkOutput("stuck1_fa", int'(fail_a), 0);
        checkOutput("stuck1_fb", int'(fail_b), 0);

        dutMode = 3;
        startSweep();
        applyStimulus(0, cycles);
        checkOutput("inv_err", int'(err_count), 256);
        startSweep();
        checkOutput("restart_err_clr", int'(err_count), 0);
        checkOutput("restart_fv_clr", int'(fail_valid), 0);
        checkOutput("restart_done_clr", int'(done), 0);
        checkOutput("restart_busy", int'(busy), 1);
        applyStimulus(0, cycles);
        checkOutput("restart_cycles", cycles, 512);
        checkOutput("restart_err", int'(err_count), 256);
`endif

        dutMode = 0;
        startSweep();
        repeat (300) @(posedge clk);
        #2;
        checkOutput("mid_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        checkIdleOutputs("midrst");
        @(negedge clk);
        checkIdleOutputs("midrst_hold");
        rst = 1'b0;

        dutMode = 1;
        startSweep();
        applyStimulus(100, cycles);
`ifdef GT_SWEEP_STOP_ON_FAIL_EN
        checkOutput("post_rst_cycles", cycles, 34);
        checkOutput("post_rst_err", int'(err_count), 1);
`else
        checkOutput("post_rst_cycles", cycles, 512);
        checkOutput("post_rst_err", int'(err_count), 120);
`endif
        checkOutput("post_rst_fa", int'(fail_a), 1);

        dutMode = 0;
        startSweep();
        applyStimulus(100, cycles);
        checkOutput("midstart_cycles", cycles, 512);
        checkOutput("midstart_err", int'(err_count), 0);
        checkOutput("midstart_pass", int'(pass), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
